// File: rtl/mbist_addr_seq_pkg.sv
// Shared codes for the MBIST address sequencer: march orders and FSM states.
package mbist_pkg;

    typedef enum logic [1:0] {
        MODE_LIN = 2'd0,
        MODE_CMP = 2'd1,
        MODE_ROW = 2'd2,
        MODE_RSV = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mbist_addr_seq_if.sv
// Controller <-> address sequencer handshake and address bus.
interface mbist_addr_seq_if #(
    parameter int ADDR_W = 8
);
    logic              START;
    logic              STEP;
    logic              ABORT;
    logic [1:0]        MODE;
    logic              DIR;
    logic [ADDR_W-1:0] ADDR_MBIST;
    logic              ADDR_VALID;
    logic              ADDR_LAST;
    logic              ADDR_DONE;
    logic              BUSY;

    modport master (
        output START, STEP, ABORT, MODE, DIR,
        input  ADDR_MBIST, ADDR_VALID, ADDR_LAST, ADDR_DONE, BUSY
    );

    modport slave (
        input  START, STEP, ABORT, MODE, DIR,
        output ADDR_MBIST, ADDR_VALID, ADDR_LAST, ADDR_DONE, BUSY
    );
endinterface

// File: rtl/mbist_addr_seq_addr_map.sv
// Combinational element-index to array-address mapping for all march orders.
module mbist_addr_map
    import mbist_pkg::*;
#(
    parameter int ROW_W = 4,
    parameter int COL_W = 3
) (
    input  logic [ROW_W+COL_W-1:0] i_idx,
    input  mode_t                  i_mode,
    input  logic                   i_dir,
    output logic [ROW_W+COL_W-1:0] o_addr
);
    localparam int AW = ROW_W + COL_W;

    logic [AW-1:0] w_j;
    logic [AW-1:0] w_half;

    // DEPTH-1-x is the bitwise inverse of x because DEPTH is a power of two.
    assign w_j    = i_dir ? ~i_idx : i_idx;
    assign w_half = w_j >> 1;

    always_comb begin
        o_addr = w_j;
        case (i_mode)
            MODE_CMP: o_addr = w_j[0] ? ~w_half : w_half;
            MODE_ROW: o_addr = {w_j[ROW_W-1:0], w_j[AW-1:ROW_W]};
            default:  o_addr = w_j;
        endcase
    end
endmodule

// File: rtl/mbist_addr_seq.sv
// MBIST address sequencer: walks every word of the array once per march element.
module mbist_addr_seq
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 3
) (
    input  logic             CLK,
    input  logic             nRESET,
    mbist_addr_seq_if.slave  bus
);
    localparam int AW = ROW_W + COL_W;
    localparam logic [AW-1:0] IDX_MAX = '1;

    state_t            r_state;
    logic [AW-1:0]     r_idx;
    mode_t             r_mode;
    logic              r_dir;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic              r_last;
    logic              r_done;

    state_t            w_state_nxt;
    logic [AW-1:0]     w_idx_nxt;
    mode_t             w_mode_nxt;
    logic              w_dir_nxt;
    logic              w_valid_nxt;
    logic              w_last_nxt;
    logic              w_done_nxt;
    logic              w_load;
    logic [AW-1:0]     w_map_addr;

    mbist_addr_map #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_map (
        .i_idx  (w_idx_nxt),
        .i_mode (w_mode_nxt),
        .i_dir  (w_dir_nxt),
        .o_addr (w_map_addr)
    );

    // Priority ABORT > START > STEP; the address register only loads on a new index.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_mode_nxt  = r_mode;
        w_dir_nxt   = r_dir;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        if (bus.ABORT) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
        end else if (bus.START) begin
            w_state_nxt = ST_RUN;
            w_idx_nxt   = '0;
            w_mode_nxt  = mode_t'(bus.MODE);
            w_dir_nxt   = bus.DIR;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (IDX_MAX == '0);
            w_load      = 1'b1;
        end else if (r_state == ST_RUN && bus.STEP) begin
            if (r_idx == IDX_MAX) begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end else begin
                w_idx_nxt   = r_idx + 1'b1;
                w_last_nxt  = (w_idx_nxt == IDX_MAX);
                w_load      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_mode  <= MODE_LIN;
            r_dir   <= 1'b0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_mode  <= w_mode_nxt;
            r_dir   <= w_dir_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_addr <= ADDR_W'(w_map_addr);
            end
        end
    end

    assign bus.ADDR_MBIST = r_addr;
    assign bus.ADDR_VALID = r_valid;
    assign bus.ADDR_LAST  = r_last;
    assign bus.ADDR_DONE  = r_done;
    assign bus.BUSY       = (r_state == ST_RUN);
endmodule
